// File: rtl/fetch_top_pkg.sv
// Shared constants and FSM encoding for the fetch stage.
package fetch_top_pkg;

    localparam int unsigned ADDR_SIZE  = 32;
    localparam int unsigned INSTR_SIZE = 32;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_1000;

    // Fetch FSM states:
    //   IfFetch - request outstanding / being issued
    //   IfHold  - data parked in the hold buffer while decode stalls
    //   IfKill  - draining a wrong-path request after a redirect
    typedef enum logic [1:0] {
        IfFetch = 2'd0,
        IfHold  = 2'd1,
        IfKill  = 2'd2
    } if_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter: next fetch address, with a redirect load port and a +4 increment.
// The load port takes the word-aligned part of the target only; the low two bits
// are always zero.
module pc_register #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-3:0] load_word,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] pc_q;

    // Load has priority over increment; arithmetic wraps mod 2^ADDR_W.
    always_comb begin
        pc_next = pc_q;
        if (load) begin
            pc_next = {load_word, 2'b00};
        end else if (inc) begin
            pc_next = pc_q + ADDR_W'(4);
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_top.sv
// FETCH stage: owns the PC, issues instruction-memory requests and drives the
// IF/ID register. Copes with variable-latency memory, decode stalls and
// redirects; wrong-path instructions are squashed into NOP bubbles.
module fetch_top
    import fetch_top_pkg::*;
#(
    parameter int unsigned        ADDR_W    = ADDR_SIZE,
    parameter int unsigned        INSTR_W   = INSTR_SIZE,
    parameter logic [ADDR_W-1:0]  RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instruction,
    output logic               out_valid
);

    if_state_e          state_q;
    logic               req_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic [ADDR_W-1:0]  hold_pc;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  out_pc_q;
    logic [INSTR_W-1:0] out_instr_q;
    logic               out_valid_q;

    logic              accept;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_next;

    // A request completes only when one is actually on the bus.
    assign accept = req_q & imem_ready;

    // PC advances when an instruction moves into IF/ID, either straight from
    // memory or out of the hold buffer; redirects take the load path instead.
    assign pc_inc = ~redirect & ~stall &
                    (((state_q == IfFetch) & accept) | (state_q == IfHold));

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk       (clk),
        .reset     (reset),
        .load      (redirect),
        .load_word (redirect_pc[ADDR_W-1:2]),
        .inc       (pc_inc),
        .pc_next   (pc_next)
    );

    // Fetch FSM, request address, hold buffer and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IfFetch;
            req_q       <= 1'b0;
            req_addr_q  <= RESET_PC;
            hold_pc     <= '0;
            hold_instr  <= '0;
            out_pc_q    <= '0;
            out_instr_q <= NOP_INSTR;
            out_valid_q <= 1'b0;
        end else if (redirect) begin
            // Flush IF/ID and drop any parked instruction, even under stall.
            out_pc_q    <= '0;
            out_instr_q <= NOP_INSTR;
            out_valid_q <= 1'b0;
            hold_pc     <= '0;
            hold_instr  <= '0;
            if (state_q == IfKill) begin
                // The old request is still on the bus; only the PC retargets.
                if (accept) begin
                    state_q    <= IfFetch;
                    req_addr_q <= pc_next;
                end
            end else if ((state_q == IfFetch) && req_q && !imem_ready) begin
                // Cannot withdraw a pending request; wait it out in KILL.
                state_q <= IfKill;
            end else begin
                state_q    <= IfFetch;
                req_q      <= 1'b1;
                req_addr_q <= pc_next;
            end
        end else begin
            case (state_q)
                IfFetch: begin
                    if (accept) begin
                        if (!stall) begin
                            out_pc_q    <= req_addr_q;
                            out_instr_q <= imem_data;
                            out_valid_q <= 1'b1;
                            req_addr_q  <= pc_next;
                        end else begin
                            // Decode is busy: park the data rather than lose it.
                            hold_pc    <= req_addr_q;
                            hold_instr <= imem_data;
                            req_q      <= 1'b0;
                            state_q    <= IfHold;
                        end
                    end else begin
                        // Also raises the very first request after reset.
                        req_q <= 1'b1;
                        if (!stall) begin
                            out_pc_q    <= '0;
                            out_instr_q <= NOP_INSTR;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                IfHold: begin
                    if (!stall) begin
                        out_pc_q    <= hold_pc;
                        out_instr_q <= hold_instr;
                        out_valid_q <= 1'b1;
                        req_q       <= 1'b1;
                        req_addr_q  <= pc_next;
                        state_q     <= IfFetch;
                    end
                end
                IfKill: begin
                    out_pc_q    <= '0;
                    out_instr_q <= NOP_INSTR;
                    out_valid_q <= 1'b0;
                    // Returned data is wrong-path; pc_q already holds the target.
                    if (accept) begin
                        req_addr_q <= pc_next;
                        state_q    <= IfFetch;
                    end
                end
                default: begin
                    state_q <= IfFetch;
                end
            endcase
        end
    end

    assign imem_req        = req_q;
    assign imem_addr       = req_addr_q;
    assign out_pc          = out_pc_q;
    assign out_instruction = out_instr_q;
    assign out_valid       = out_valid_q;

endmodule

// File: tb/tb_fetch_top.sv
// Bench for fetch_top: directed stimulus, a behavioural instruction memory with
// per-address latency, and a scoreboard monitor on the IF/ID register.
module tb_fetch_top;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    // Memory latency: every address is 0-wait except slow_addr.
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int unsigned slow_lat  = 1;
    int unsigned mem_cnt   = 0;

    fetch_top u_dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_data       (imem_data),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_valid       (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h0000_1008) return 32'hDEAD_BEEF;
        return (a ^ 32'hA5A5_0000) + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = data_of(pc);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_reset();
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Instruction memory: answers after the configured number of request cycles.
    always @(negedge clk) begin
        int unsigned lat;
        lat = (imem_addr == slow_addr) ? slow_lat : 1;
        if (!imem_req) begin
            imem_ready = 1'b0;
            mem_cnt    = 0;
        end else begin
            if (imem_ready) mem_cnt = 0;
            if (mem_cnt + 1 >= lat) begin
                imem_ready = 1'b1;
                imem_data  = data_of(imem_addr);
            end else begin
                imem_ready = 1'b0;
                imem_data  = 32'hBAD0_0000;
                mem_cnt++;
            end
        end
    end

    // Scoreboard monitor: IF/ID is loaded on every edge where stall was low.
    initial begin
        logic s;
        logic r;
        exp_t e;
        forever begin
            @(posedge clk);
            s = stall;
            r = reset;
            #1;
            if (!r && !reset) begin
                if (out_valid && !s) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid: got pc %h instr %h want none",
                                 out_pc, out_instruction);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", out_pc, e.pc);
                        chk("sb_instr", out_instruction, e.instr);
                    end
                end else if (!out_valid) begin
                    chk("bubble_nop", out_instruction, 32'h0000_0000);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1 reset = 1'b1;
        step();
        step();

        // Reset values
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instruction, 32'h0);
        chk1("rst_req", imem_req, 1'b0);

        // T1 + T3: 0-wait stream, then stall on the cycle 0x1008 returns
        push(32'h1000);
        push(32'h1004);
        push(32'h1008);
        reset = 1'b0;
        step();
        chk1("t1_req", imem_req, 1'b1);
        chk("t1_addr0", imem_addr, 32'h1000);
        chk1("t1_valid0", out_valid, 1'b0);
        step();
        chk("t1_addr1", imem_addr, 32'h1004);
        chk("t1_out0", out_pc, 32'h1000);
        step();
        chk("t1_addr2", imem_addr, 32'h1008);
        stall = 1'b1;
        step();
        chk1("t3_req_stalled", imem_req, 1'b0);
        chk("t3_hold_pc", out_pc, 32'h1004);
        chk1("t3_hold_valid", out_valid, 1'b1);
        step();
        chk1("t3_req_stalled2", imem_req, 1'b0);
        chk("t3_hold_instr", out_instruction, data_of(32'h1004));
        stall = 1'b0;
        step();
        chk("t3_instr", out_instruction, 32'hDEAD_BEEF);
        chk("t3_pc", out_pc, 32'h1008);
        chk("t3_next_addr", imem_addr, 32'h100C);
        start_reset();

        // T2: 3-cycle memory at 0x1000
        slow_addr = 32'h1000;
        slow_lat  = 3;
        push(32'h1000);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_addr_wait", imem_addr, 32'h1000);
            chk1("t2_req_wait", imem_req, 1'b1);
            chk1("t2_valid_wait", out_valid, 1'b0);
        end
        step();
        chk("t2_out_pc", out_pc, 32'h1000);
        chk1("t2_out_valid", out_valid, 1'b1);
        chk("t2_next_addr", imem_addr, 32'h1004);
        start_reset();
        slow_addr = 32'hFFFF_FFFF;

        // T4: redirect with stall, 0-wait memory
        push(32'h1000);
        push(32'h2000);
        reset = 1'b0;
        step();
        step();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h2003;
        step();
        chk1("t4_flush_valid", out_valid, 1'b0);
        chk("t4_flush_pc", out_pc, 32'h0);
        chk("t4_addr", imem_addr, 32'h2000);
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        chk("t4_target_pc", out_pc, 32'h2000);
        chk1("t4_target_valid", out_valid, 1'b1);
        start_reset();

        // T5: redirect during a 4-cycle miss at 0x1010
        slow_addr = 32'h1010;
        slow_lat  = 4;
        push(32'h1000);
        push(32'h1004);
        push(32'h1008);
        push(32'h100C);
        push(32'h3000);
        reset = 1'b0;
        repeat (5) step();
        chk("t5_miss_addr", imem_addr, 32'h1010);
        redirect    = 1'b1;
        redirect_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            step();
            redirect = 1'b0;
            chk("t5_kill_addr", imem_addr, 32'h1010);
            chk1("t5_kill_req", imem_req, 1'b1);
            chk1("t5_kill_valid", out_valid, 1'b0);
        end
        step();
        chk("t5_new_addr", imem_addr, 32'h3000);
        chk1("t5_new_valid", out_valid, 1'b0);
        step();
        chk("t5_target_pc", out_pc, 32'h3000);
        chk1("t5_target_valid", out_valid, 1'b1);
        start_reset();
        slow_addr = 32'hFFFF_FFFF;

        // PC wrap at the top of the address space
        push(32'hFFFF_FFF8);
        push(32'hFFFF_FFFC);
        push(32'h0000_0000);
        reset = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF9;
        step();
        redirect = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        step();
        chk("wrap_addr2", imem_addr, 32'h0);
        step();
        chk("wrap_out_pc", out_pc, 32'h0);
        chk1("wrap_out_valid", out_valid, 1'b1);
        chk("wrap_next_addr", imem_addr, 32'h4);
        start_reset();

        // T6a: async reset while in HOLD
        push(32'h1000);
        reset = 1'b0;
        step();
        step();
        stall = 1'b1;
        step();
        chk1("t6_hold_req", imem_req, 1'b0);
        chk1("t6_hold_valid", out_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk1("t6a_valid", out_valid, 1'b0);
        chk("t6a_pc", out_pc, 32'h0);
        chk("t6a_instr", out_instruction, 32'h0);
        chk1("t6a_req", imem_req, 1'b0);
        stall = 1'b0;
        step();
        step();

        // T6b: async reset mid-miss; the dropped hold buffer must not resurface
        slow_addr = 32'h1004;
        slow_lat  = 4;
        push(32'h1000);
        reset = 1'b0;
        step();
        chk("t6b_first_addr", imem_addr, 32'h1000);
        chk1("t6b_first_req", imem_req, 1'b1);
        step();
        chk("t6b_miss_addr", imem_addr, 32'h1004);
        chk1("t6b_miss_valid", out_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk1("t6b_valid", out_valid, 1'b0);
        chk("t6b_pc", out_pc, 32'h0);
        chk1("t6b_req", imem_req, 1'b0);
        step();
        step();
        slow_addr = 32'hFFFF_FFFF;

        // Fetch restarts at RESET_PC after the mid-miss reset
        push(32'h1000);
        reset = 1'b0;
        step();
        chk("t6c_first_addr", imem_addr, 32'h1000);
        step();
        chk("t6c_out_pc", out_pc, 32'h1000);
        chk1("t6c_out_valid", out_valid, 1'b1);
        start_reset();

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
